// File: rtl/output_classifier_pkg.sv
// ----------------------------------------------------------------------------
// output_classifier_pkg
// Shared fixed-point definitions for the neural network datapath and its
// consumers.
//   INTEGER_WIDTH / FRACTION_WIDTH : fixed-point format of every neuron value
//   fixed_t                        : signed value with integral/fraction views
//   fixed_gt()                     : signed strictly-greater comparison
//   layer_t / layer_builder()      : description of one network layer
// ----------------------------------------------------------------------------
package output_classifier_pkg;

    localparam int INTEGER_WIDTH  = 8;
    localparam int FRACTION_WIDTH = 8;
    localparam int FIXED_WIDTH    = INTEGER_WIDTH + FRACTION_WIDTH;

    // Bit layout is [INTEGER_WIDTH-1:-FRACTION_WIDTH]; the integral field
    // carries the sign, so the whole vector is a two's-complement number.
    typedef struct packed {
        logic signed [INTEGER_WIDTH-1:0]  integral;
        logic        [FRACTION_WIDTH-1:0] fraction;
    } fixed_t;

    // Packed structs compare unsigned by default; force a signed view.
    function automatic logic fixed_gt(input fixed_t a, input fixed_t b);
        return $signed(a) > $signed(b);
    endfunction

    typedef struct packed {
        int unsigned SIZE;
    } layer_t;

    function automatic layer_t layer_builder(input int unsigned size);
        layer_t l;
        l.SIZE = size;
        return l;
    endfunction

endpackage

// File: rtl/output_classifier.sv
// ----------------------------------------------------------------------------
// output_classifier
// Captures the network result vector on each rising edge of outputs_ready,
// scans it one element per cycle for the largest signed value (lowest index
// wins ties) and offers the winner downstream with a valid/ready handshake.
// Ports:
//   clock, reset       : clock, asynchronous active-high reset
//   outputs_ready      : level, high while outputs holds a valid result
//   outputs[]          : NUM_OUTPUTS fixed-point results
//   class_ready        : downstream accepts the current result
//   class_valid        : result available (DONE state)
//   class_index/value  : index and value of the maximum output
//   busy               : high while scanning or holding a result
//   overrun            : sticky, a new result arrived while not idle
// ----------------------------------------------------------------------------
module output_classifier
    import output_classifier_pkg::*;
#(
    parameter int NUM_OUTPUTS = 10,
    parameter int INDEX_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   outputs_ready,
    input  fixed_t                 outputs [NUM_OUTPUTS],
    input  logic                   class_ready,
    output logic                   class_valid,
    output logic [INDEX_WIDTH-1:0] class_index,
    output fixed_t                 class_value,
    output logic                   busy,
    output logic                   overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_OUTPUTS - 1);

    state_t                 r_state;
    logic                   r_ready_q;
    logic [INDEX_WIDTH-1:0] r_i;
    logic [INDEX_WIDTH-1:0] r_max_idx;
    fixed_t                 r_max_val;
    fixed_t                 r_buf [NUM_OUTPUTS];
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_overrun;

    logic                   w_new_result;
    fixed_t                 w_cand;

    // A level already high when reset releases counts as a new result,
    // because r_ready_q comes out of reset low.
    assign w_new_result = outputs_ready && !r_ready_q;
    assign w_cand       = r_buf[r_i];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ready_q <= 1'b0;
            r_i       <= '0;
            r_max_idx <= '0;
            r_max_val <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_ready_q <= outputs_ready;

            // Results arriving while busy are dropped; the buffer is untouched.
            if (w_new_result && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_new_result) begin
                        r_buf     <= outputs;
                        r_max_val <= outputs[0];
                        r_max_idx <= '0;
                        r_i       <= INDEX_WIDTH'(1);
                        r_busy    <= 1'b1;
                        if (NUM_OUTPUTS == 1) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end

                S_SCAN: begin
                    // Strictly greater keeps the earliest index on ties.
                    if (fixed_gt(w_cand, r_max_val)) begin
                        r_max_val <= w_cand;
                        r_max_idx <= r_i;
                    end
                    if (r_i == LAST_IDX) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end

                S_DONE: begin
                    if (class_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign class_valid = r_valid;
    assign class_index = r_max_idx;
    assign class_value = r_max_val;
    assign busy        = r_busy;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_output_classifier.sv
// ----------------------------------------------------------------------------
// tb_output_classifier
// Directed bench for output_classifier with a scoreboard: the expected
// winner is pushed when a result is offered and popped when the DUT hands
// a result downstream.
// ----------------------------------------------------------------------------
module tb_output_classifier;
    import output_classifier_pkg::*;

    localparam int N  = 10;
    localparam int IW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          outputs_ready = 1'b0;
    logic          class_ready = 1'b0;
    fixed_t        outputs_v [N];
    logic          class_valid;
    logic [IW-1:0] class_index;
    fixed_t        class_value;
    logic          busy;
    logic          overrun;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    output_classifier #(.NUM_OUTPUTS(N), .INDEX_WIDTH(IW)) dut (
        .clock         (clock),
        .reset         (reset),
        .outputs_ready (outputs_ready),
        .outputs       (outputs_v),
        .class_ready   (class_ready),
        .class_valid   (class_valid),
        .class_index   (class_index),
        .class_value   (class_value),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference winner: first index holding the largest signed value.
    function automatic exp_t ref_max();
        exp_t e;
        int   best;
        best = 0;
        for (int k = 1; k < N; k++) begin
            if ($signed(outputs_v[k]) > $signed(outputs_v[best])) best = k;
        end
        e.idx = best;
        e.val = outputs_v[best];
        return e;
    endfunction

    task automatic set_all(input logic [15:0] v);
        for (int k = 0; k < N; k++) outputs_v[k] = v;
    endtask

    task automatic set_random();
        for (int k = 0; k < N; k++) outputs_v[k] = 16'($urandom);
    endtask

    // Called after the capture edge; lat is the number of edges already seen
    // beyond the capture edge.
    task automatic wait_valid(input string tag, input int start_lat, input int exp_lat);
        int lat;
        lat = start_lat;
        while (!class_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    // Scoreboard consumer: a transfer happens on the next rising edge.
    always @(negedge clock) begin
        if (!reset && class_valid && class_ready) begin
            exp_t e;
            check("sb_pending", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("xfer: index=%0d value=%04h (expected %0d %04h)",
                         class_index, class_value, e.idx, e.val);
                check("sb_index", 32'(class_index), e.idx);
                check("sb_value", 32'(class_value), 32'(e.val));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   cnt;

        set_all(16'h0000);
        tick();
        tick();
        check("rst_valid",   32'(class_valid), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_index",   32'(class_index), 0);
        check("rst_value",   32'(class_value), 0);
        reset = 1'b0;
        tick();

        // Single maximum, ready held high
        outputs_v[0] = 16'h0040;
        outputs_v[1] = 16'h0080;
        outputs_v[7] = 16'h0300;
        class_ready   = 1'b1;
        outputs_ready = 1'b1;
        sb.push_back(ref_max());
        tick();
        check("single_busy",  32'(busy), 1);
        check("single_valid0", 32'(class_valid), 0);
        wait_valid("single", 0, 9);
        check("single_index", 32'(class_index), 7);
        check("single_value", 32'(class_value), 32'h0300);
        tick();
        check("single_valid_low", 32'(class_valid), 0);
        check("single_idle", 32'(busy), 0);
        outputs_ready = 1'b0;
        tick();

        // Ties and negatives
        set_all(16'hFE80);
        outputs_v[2] = 16'hFFC0;
        outputs_v[5] = 16'hFFC0;
        outputs_ready = 1'b1;
        sb.push_back(ref_max());
        tick();
        wait_valid("tie", 0, 9);
        check("tie_index", 32'(class_index), 2);
        check("tie_value", 32'(class_value), 32'hFFC0);
        tick();
        outputs_ready = 1'b0;
        tick();

        // Backpressure with inputs trashed after capture
        class_ready = 1'b0;
        set_random();
        e = ref_max();
        sb.push_back(e);
        outputs_ready = 1'b1;
        tick();
        set_all(16'h7FFF);
        wait_valid("bp", 0, 9);
        for (int c = 0; c < 20; c++) begin
            check("bp_valid", 32'(class_valid), 1);
            check("bp_index", 32'(class_index), e.idx);
            check("bp_value", 32'(class_value), 32'(e.val));
            tick();
        end
        check("bp_no_overrun", 32'(overrun), 0);
        class_ready = 1'b1;
        tick();
        check("bp_valid_low", 32'(class_valid), 0);
        check("bp_idle", 32'(busy), 0);
        outputs_ready = 1'b0;
        tick();

        // Overrun during SCAN at cycle 4
        set_random();
        sb.push_back(ref_max());
        outputs_ready = 1'b1;
        tick();                 // capture edge E0
        outputs_ready = 1'b0;
        set_all(16'h7FFF);      // would win if the buffer were reloaded
        tick();
        tick();
        tick();                 // E3
        outputs_ready = 1'b1;
        tick();                 // E4: rising edge while scanning
        check("ovr_set", 32'(overrun), 1);
        check("ovr_busy", 32'(busy), 1);
        wait_valid("ovr", 4, 9);
        tick();
        check("ovr_sticky", 32'(overrun), 1);
        outputs_ready = 1'b0;
        tick();
        set_random();
        sb.push_back(ref_max());
        outputs_ready = 1'b1;
        tick();
        check("ovr_recapture_busy", 32'(busy), 1);
        wait_valid("ovr_next", 0, 9);
        tick();
        check("ovr_still_set", 32'(overrun), 1);
        outputs_ready = 1'b0;
        tick();

        // Level held high for 50 cycles gives one result
        set_random();
        sb.push_back(ref_max());
        outputs_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (class_valid) cnt++;
        end
        check("level_one_result", cnt, 1);
        outputs_ready = 1'b0;
        tick();

        // Reset mid-SCAN, level high at release
        set_random();
        outputs_ready = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid",   32'(class_valid), 0);
        check("mid_rst_busy",    32'(busy), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_index",   32'(class_index), 0);
        check("mid_rst_value",   32'(class_value), 0);
        tick();
        tick();
        check("mid_rst_hold", 32'(class_valid), 0);
        set_random();
        sb.push_back(ref_max());
        reset = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 1);
        wait_valid("post_rst", 0, 9);
        tick();
        outputs_ready = 1'b0;
        tick();
        tick();

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/output_classifier.md
# output_classifier

Consumer at the output end of `neural_network`. On each new result (rising edge of `outputs_ready`) it captures the `outputs` vector and scans it sequentially for the largest signed fixed-point value. It then presents the winning class index and value to downstream logic (display or UART) with a valid/ready handshake. It replaces bench-side `$display` inspection in the synthesised top level.

## Interface
- `NUM_OUTPUTS`, default 10: number of output neurons; must be ≥ 1 and must equal the last layer's `SIZE`.
- `INDEX_WIDTH`, default `$clog2(NUM_OUTPUTS)` (minimum 1): width of `class_index`.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `outputs_ready`  in  1  level from `neural_network`; high while `outputs` holds a valid result.
- `outputs[NUM_OUTPUTS]`  in  signed `[INTEGER_WIDTH-1:-FRACTION_WIDTH]` each  network results.
- `class_ready`  in  1  downstream accepts the current result.
- `class_valid`  out  1  result available.
- `class_index`  out  `INDEX_WIDTH`  index of the maximum output.
- `class_value`  out  signed `[INTEGER_WIDTH-1:-FRACTION_WIDTH]`  the maximum value.
- `busy`  out  1  high in SCAN and DONE.
- `overrun`  out  1  sticky; a new result arrived while not IDLE. Cleared only by `reset`.

## Operation
- **Edge detect:** register `ready_q`, reset value 0. A new result is `outputs_ready && !ready_q`. Consequently, a level already high when reset releases counts as a new result.
- **States:**
  - IDLE: `busy` = 0, `class_valid` = 0.
  - SCAN: `busy` = 1.
  - DONE: `busy` = 1, `class_valid` = 1.
- **IDLE → capture:** on a new result:
  - copy all `outputs` into buffer `buf`;
  - set `max_val` = `outputs[0]`, `max_idx` = 0, counter `i` = 1;
  - go to SCAN, or directly to DONE if `NUM_OUTPUTS` = 1.
- **SCAN:** each cycle:
  - if `buf[i] > max_val` (signed, strictly greater), load `max_val`/`max_idx` from `buf[i]`/`i`;
  - when `i` = `NUM_OUTPUTS-1`, go to DONE; otherwise `i` increments.
- **Ties:** on equal values the lowest index wins.
- **DONE:**
  - `class_index`/`class_value` are driven from `max_idx`/`max_val` and held stable.
  - On an edge with `class_ready` = 1, go to IDLE.
- **Overrun:** a new result seen in SCAN or DONE is ignored (buffer untouched) and sets `overrun`.
- **Arithmetic:** comparison only; no widening or saturation. `buf` is the only copy of the data, so `outputs` may change after the capture edge.

## Timing
- **Reset values** (asynchronous, immediate):
  - state = IDLE, `ready_q` = 0, `i` = 0;
  - `class_valid`, `busy`, `overrun` = 0;
  - `class_index`, `class_value`, `max_*`, `buf` = 0.
- **Latency:** capture at edge E0. `class_valid` is high after edge E0+`NUM_OUTPUTS`−1 (9 cycles for 10 outputs; same edge for `NUM_OUTPUTS` = 1).
- **Handshake:**
  - Transfer occurs on an edge where `class_valid && class_ready`.
  - `class_valid` is low the following cycle.
  - `class_ready` may be held high permanently, which gives a one-cycle DONE.
- **Back-to-back:** a rising edge of `outputs_ready` on the transfer edge is an overrun (state was DONE). A rising edge in IDLE, one cycle after transfer, is accepted.
- **Mid-operation reset:** aborts SCAN/DONE with no partial result emitted. `overrun` clears.
- **Level behaviour:** `outputs_ready` staying high never retriggers; it must fall and rise again.

## Structure
- **Shared package (`include.svh`):**
  - `INTEGER_WIDTH` and `FRACTION_WIDTH`;
  - a `fixed_t` typedef for the signed `[INTEGER_WIDTH-1:-FRACTION_WIDTH]` type (with `integral`/`fraction` views as used elsewhere);
  - `layer_builder`.
- **Local to the module:** the state enum (IDLE, SCAN, DONE).
- **Sub-modules:** none. The comparator is one expression, and the edge detector is one flop.
- **Top-level connection:** instantiate beside `neural_network` with `NUM_OUTPUTS` = `LAYERS[NUM_LAYERS-1].SIZE`.

## Test plan
- **Single maximum:** outputs = {0.25, 0.5, 3.0 at index 7, rest 0}, rising `outputs_ready`, `class_ready` = 1 → `class_valid` high exactly 9 cycles after the capture edge with index 7, value 3.0. Low the next cycle.
- **Ties and negatives:** all outputs −1.5 except indices 2 and 5 = −0.25 → index 2, value −0.25. Confirms signed compare and that the lowest index wins a tie.
- **Backpressure and data hold:** `class_ready` = 0 for 20 cycles, and `outputs` changed to garbage after capture → `class_valid`/index/value stable throughout. Transfer on the first `class_ready` = 1 edge, then IDLE.
- **Overrun:** second rising `outputs_ready` during SCAN (cycle 4) → first result unaffected and `overrun` = 1 and stays 1. A rising edge after return to IDLE → new result processed.
- **Level hold:** `outputs_ready` held high for 50 cycles → exactly one result produced.
- **Reset mid-SCAN (cycle 3):** all outputs immediately at reset values, no `class_valid`. `outputs_ready` high at release → fresh capture and correct result.
